seven_seg_scan: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It captures a packed BCD/hex value and scans one digit per refresh slot. Each digit is decoded to active-low segments with optional hex glyphs, decimal points, per-digit blanking and leading-zero blanking. It sits between the datapath registers and the board pins and supersedes the single-digit combinational decoder at the top level.

---
 rtl/seven_seg_pkg.sv | 51 +++++
 rtl/seven_seg_decode.sv | 12 +
 rtl/seven_seg_scan.sv | 126 ++++++++++++
 tb/tb_seven_seg_scan.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - glyph constants and code-to-glyph decode for the seven-segment scanner
// Segments are active low, bit 6 = a ... bit 0 = g.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0     = 7'b0000001;
  localparam seg_t GLYPH_1     = 7'b1001111;
  localparam seg_t GLYPH_2     = 7'b0010010;
  localparam seg_t GLYPH_3     = 7'b0000110;
  localparam seg_t GLYPH_4     = 7'b1001100;
  localparam seg_t GLYPH_5     = 7'b0100100;
  localparam seg_t GLYPH_6     = 7'b0100000;
  localparam seg_t GLYPH_7     = 7'b0001111;
  localparam seg_t GLYPH_8     = 7'b0000000;
  localparam seg_t GLYPH_9     = 7'b0000100;
  localparam seg_t GLYPH_A     = 7'b0001000;
  localparam seg_t GLYPH_B     = 7'b1100000;
  localparam seg_t GLYPH_C     = 7'b0110001;
  localparam seg_t GLYPH_D     = 7'b1000010;
  localparam seg_t GLYPH_E     = 7'b0110000;
  localparam seg_t GLYPH_F     = 7'b0111000;
  localparam seg_t GLYPH_BLANK = 7'b1111111;

  function automatic seg_t decode_glyph(input logic [3:0] code, input logic hex_en);
    seg_t g;
    case (code)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    if (!hex_en && (code > 4'd9)) begin
      g = GLYPH_BLANK;
    end
    return g;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// rtl/seven_seg_decode.sv - combinational digit code to active-low glyph
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output seg_t       glyph
);

  assign glyph = decode_glyph(code, hex_en);

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed N-digit common-anode seven-segment driver
// Double-buffered digit banks swap on the frame boundary so a frame is never torn.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter bit HEX_EN       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lzb_en_i,
  input  logic                    load_i,
  output seg_t                    seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]         BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  logic [1:0] rst_sync;
  logic       rst_int_n;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          frame_now;

  logic [VW-1:0]         pend_val, act_val;
  logic [NUM_DIGITS-1:0] pend_dp, act_dp;
  logic [NUM_DIGITS-1:0] pend_blank, act_blank;

  logic [3:0] cur_code;
  logic       upper_zero;
  logic       digit_blank;
  seg_t       glyph;

  // Assertion propagates straight through the chain; release waits two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign frame_now = (idx == IDX_LAST) && (presc == PRESC_LAST);

  // A load landing on the commit cycle bypasses pending so it is not lost for a frame.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (load_i) begin
        pend_val   <= value_i;
        pend_dp    <= dp_i;
        pend_blank <= blank_i;
      end
      if (frame_now) begin
        act_val   <= load_i ? value_i : pend_val;
        act_dp    <= load_i ? dp_i    : pend_dp;
        act_blank <= load_i ? blank_i : pend_blank;
      end
    end
  end

  assign cur_code    = act_val[{idx, 2'b00} +: 4];
  assign upper_zero  = ((act_val >> {idx, 2'b00}) == '0);
  assign digit_blank = act_blank[idx] || (lzb_en_i && (idx != '0) && upper_zero);

  seven_seg_decode u_decode (
    .code   (cur_code),
    .hex_en (HEX_EN),
    .glyph  (glyph)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      an_o    <= '1;
      seg_o   <= GLYPH_BLANK;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      frame_o <= frame_now;
      if (presc < BLANK_END) begin
        an_o  <= '1;
        seg_o <= GLYPH_BLANK;
        dp_o  <= 1'b1;
      end else begin
        an_o  <= ~(AN_ONE << idx);
        seg_o <= digit_blank ? GLYPH_BLANK : glyph;
        dp_o  <= digit_blank | ~act_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard bench for seven_seg_scan with hex and non-hex instances
module tb_seven_seg_scan;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;
  localparam int F = N * R;
  localparam logic [12:0] RST_OUT = {4'b1111, 7'h7F, 1'b1, 1'b0};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4*N-1:0]  value_i;
  logic [N-1:0]    dp_i;
  logic [N-1:0]    blank_i;
  logic            lzb_en_i;
  logic            load_i;

  logic [6:0]   seg_h, seg_n;
  logic         dp_h, dp_n, fr_h, fr_n;
  logic [N-1:0] an_h, an_n;

  logic [6:0] glyph_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [12:0] q_hex[$];
  logic [12:0] q_nohex[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cur_c    = -1;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .HEX_EN(1'b1)) u_hex (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
    .lzb_en_i(lzb_en_i), .load_i(load_i), .seg_o(seg_h), .dp_o(dp_h), .an_o(an_h), .frame_o(fr_h)
  );

  seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .HEX_EN(1'b0)) u_nohex (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
    .lzb_en_i(lzb_en_i), .load_i(load_i), .seg_o(seg_n), .dp_o(dp_n), .an_o(an_n), .frame_o(fr_n)
  );

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t got an=%b seg=%b dp=%b fr=%b want an=%b seg=%b dp=%b fr=%b",
               name, $time, got[12:9], got[8:2], got[1], got[0],
               want[12:9], want[8:2], want[1], want[0]);
    end
  endtask

  // Expected pins for model cycle c, derived from slot arithmetic on the cycle number.
  function automatic logic [12:0] expect_out(input int c, input logic hex, input logic [15:0] val,
                                             input logic [3:0] dpa, input logic [3:0] bla,
                                             input logic lzb);
    int digit;
    int phase;
    logic fr;
    logic [3:0] code;
    logic [3:0] an;
    logic [6:0] seg;
    logic blank;
    digit = (c / R) % N;
    phase = c % R;
    fr    = ((c % F) == F - 1);
    if (phase < B) return {4'b1111, 7'h7F, 1'b1, fr};
    code  = val[4*digit +: 4];
    blank = bla[digit] || (lzb && digit != 0 && (val >> (4*digit)) == 16'h0);
    if (blank || (!hex && code > 4'd9)) seg = 7'h7F;
    else seg = glyph_tab[code];
    an = 4'b1111;
    an[digit] = 1'b0;
    return {an, seg, blank ? 1'b1 : ~dpa[digit], fr};
  endfunction

  // Reference model: two synchroniser edges after release, then one output per cycle.
  initial begin
    int rcnt;
    int c;
    logic [15:0] p_val, a_val;
    logic [3:0]  p_dp, a_dp, p_bl, a_bl;
    rcnt = 0;
    p_val = '0; a_val = '0; p_dp = '0; a_dp = '0; p_bl = '0; a_bl = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        rcnt = 0;
        p_val = '0; a_val = '0; p_dp = '0; a_dp = '0; p_bl = '0; a_bl = '0;
        q_hex.push_back(RST_OUT);
        q_nohex.push_back(RST_OUT);
        cur_c = -1;
      end else begin
        rcnt++;
        if (rcnt < 3) begin
          q_hex.push_back(RST_OUT);
          q_nohex.push_back(RST_OUT);
        end else begin
          c = rcnt - 3;
          q_hex.push_back(expect_out(c, 1'b1, a_val, a_dp, a_bl, lzb_en_i));
          q_nohex.push_back(expect_out(c, 1'b0, a_val, a_dp, a_bl, lzb_en_i));
          if ((c % F) == F - 1) begin
            a_val = load_i ? value_i : p_val;
            a_dp  = load_i ? dp_i    : p_dp;
            a_bl  = load_i ? blank_i : p_bl;
          end
          if (load_i) begin
            p_val = value_i;
            p_dp  = dp_i;
            p_bl  = blank_i;
          end
        end
        cur_c = (rcnt >= 2) ? rcnt - 2 : -1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (q_hex.size() > 0) check("hex_out", {an_h, seg_h, dp_h, fr_h}, q_hex.pop_front());
      if (q_nohex.size() > 0) check("nohex_out", {an_n, seg_n, dp_n, fr_n}, q_nohex.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_mod(input int m);
    for (int k = 0; k < F + 4; k++) begin
      if (cur_c >= 0 && (cur_c % F) == m) return;
      @(posedge clk);
      #1;
    end
    check("wait_mod_timeout", 13'd0, 13'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value_i = v;
    dp_i    = d;
    blank_i = b;
    load_i  = 1'b1;
    @(posedge clk);
    #1;
    load_i  = 1'b0;
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; value_i = '0; dp_i = '0; blank_i = '0; lzb_en_i = 1'b0; load_i = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(F + 4);

    do_load(16'h1234, 4'b0000, 4'b0000);
    idle(2 * F);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    idle(2 * F);

    lzb_en_i = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    idle(2 * F);
    do_load(16'h0000, 4'b0000, 4'b0000);
    idle(2 * F);
    lzb_en_i = 1'b0;

    do_load(16'h9999, 4'b0100, 4'b0001);
    idle(2 * F);

    wait_mod(F - 1);
    do_load(16'h5555, 4'b0000, 4'b0000);
    wait_mod(6);
    do_load(16'h7777, 4'b0000, 4'b0000);
    idle(3 * F);

    for (int i = 0; i < 25; i++) begin
      idle($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) lzb_en_i = ~lzb_en_i;
      do_load(rand_value(), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
    end
    idle(2 * F);

    lzb_en_i = 1'b0;
    do_load(16'h8642, 4'b1010, 4'b0000);
    idle(2 * F);
    wait_mod(2 * R + 2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_hex", {an_h, seg_h, dp_h, fr_h}, RST_OUT);
    check("async_reset_nohex", {an_n, seg_n, dp_n, fr_n}, RST_OUT);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3 * F);

    @(negedge clk);
    #1;
    check("drain_hex", 13'(q_hex.size()), 13'd0);
    check("drain_nohex", 13'(q_nohex.size()), 13'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
